// File: rtl/multiword_add_seq.sv
// Multi-word adder sequencer: adds two N*WORDS-bit operands one N-bit chunk per cycle,
// LSB chunk first, and presents the full-width sum with carry and signed-overflow flags.
module multiword_add_seq #(
    parameter int N     = 8,
    parameter int WORDS = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [N*WORDS-1:0] a,
    input  logic [N*WORDS-1:0] b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [N*WORDS-1:0] sum,
    output logic               carry_out,
    output logic               overflow
);

    localparam int W  = N * WORDS;
    localparam int CW = (WORDS > 1) ? $clog2(WORDS) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [CW-1:0]  cnt;
    logic           carry;
    logic [W-1:0]   a_q;
    logic [W-1:0]   b_q;
    logic [N:0]     chunk_sum;
    logic           last;

    // One shared N-bit adder; the chunk counter selects which slice feeds it.
    always_comb begin
        chunk_sum = {1'b0, a_q[int'(cnt)*N +: N]}
                  + {1'b0, b_q[int'(cnt)*N +: N]}
                  + {{N{1'b0}}, carry};
        last      = (cnt == CW'(WORDS - 1));
    end

    // NOTE: every signal gets a default at the top of the block, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
        unique case (state)
            IDLE:    if (in_valid)  state_nxt = RUN;
            RUN:     if (last)      state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    // NOTE: clocked state uses non-blocking assignments only, so every register sees
    // the pre-edge value of every other register regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            carry     <= 1'b0;
            sum       <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        cnt   <= '0;
                        carry <= 1'b0;
                    end
                end
                RUN: begin
                    sum[int'(cnt)*N +: N] <= chunk_sum[N-1:0];
                    carry                 <= chunk_sum[N];
                    cnt                   <= cnt + 1'b1;
                    if (last) begin
                        carry_out <= chunk_sum[N];
                        // Top chunk's MSB is the sign of the full-width sum.
                        overflow  <= (a_q[W-1] == b_q[W-1]) && (chunk_sum[N-1] != a_q[W-1]);
                    end
                end
                default: ;
            endcase
        end
    end

    // NOTE: operand registers carry no reset; they are always loaded at accept before
    // being read, so resetting them would only add reset fan-out.
    always_ff @(posedge clk) begin
        if (state == IDLE && in_valid) begin
            a_q <= a;
            b_q <= b;
        end
    end

endmodule

// File: tb/tb_multiword_add_seq.sv
// Self-checking bench for multiword_add_seq: directed corner cases plus randomized
// back-to-back traffic compared every cycle against a transaction-level model.
module tb_multiword_add_seq;

    localparam int N     = 8;
    localparam int WORDS = 4;
    localparam int W     = N * WORDS;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         carry_out;
    logic         overflow;

    int errors = 0;
    int checks = 0;

    multiword_add_seq #(.N(N), .WORDS(WORDS)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .carry_out (carry_out),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: one operation in flight, result due WORDS+1 cycles
    // after the cycle in which the handshake is seen.
    bit           mon_en   = 1'b0;
    bit           seen_rst = 1'b0;
    bit           prev_rst = 1'b0;
    bit           busy     = 1'b0;
    bit           b2b      = 1'b0;
    bit           exp_valid;
    int           age      = 0;
    int           cyc      = 0;
    int           last_acc = -1;
    logic [W-1:0] exp_sum;
    logic         exp_co;
    logic         exp_ov;

    always @(negedge clk) begin
        if (mon_en) begin
            cyc++;
            if (busy) age++;
            exp_valid = busy && (age >= WORDS + 1);
            if (seen_rst) begin
                check("in_ready", in_ready, !busy);
                check("out_valid", out_valid, exp_valid);
                if (exp_valid) begin
                    check("sum", sum, exp_sum);
                    check("carry_out", carry_out, exp_co);
                    check("overflow", overflow, exp_ov);
                end
                if (prev_rst) begin
                    check("rst_sum", sum, 0);
                    check("rst_carry_out", carry_out, 0);
                    check("rst_overflow", overflow, 0);
                end
            end
            if (rst) begin
                busy     = 1'b0;
                seen_rst = 1'b1;
                prev_rst = 1'b1;
            end else begin
                prev_rst = 1'b0;
                if (exp_valid && out_ready) begin
                    busy = 1'b0;
                end else if (!busy && in_valid) begin
                    busy              = 1'b1;
                    age               = 0;
                    {exp_co, exp_sum} = {1'b0, a} + {1'b0, b};
                    exp_ov            = (a[W-1] == b[W-1]) && (exp_sum[W-1] != a[W-1]);
                    if (b2b && last_acc >= 0) check("op_spacing", cyc - last_acc, WORDS + 2);
                    last_acc = cyc;
                end
            end
        end
    end

    // Present operands until accepted; afterwards scramble a/b to prove they were captured.
    task automatic send(input logic [W-1:0] va, input logic [W-1:0] vb, input bit hold);
        int n;
        bit hs;
        a        = va;
        b        = vb;
        in_valid = 1'b1;
        n        = 0;
        hs       = 1'b0;
        while (!hs && n < 100) begin
            @(negedge clk);
            hs = in_ready && !rst;
            @(posedge clk);
            #1;
            n++;
        end
        if (!hs) check("send_timeout", hs, 1);
        if (!hold) in_valid = 1'b0;
        a = $urandom;
        b = $urandom;
    endtask

    task automatic expect_result(input string name, input logic [W-1:0] es, input logic eco,
                                 input logic eov);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 100);
        if (!out_valid) check({name, "_timeout"}, out_valid, 1);
        check({name, "_sum"}, sum, es);
        check({name, "_co"}, carry_out, eco);
        check({name, "_ov"}, overflow, eov);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = '0;
        b         = '0;
        mon_en    = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
        expect_result("t1", 32'h0000_0000, 1'b1, 1'b0);
        send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
        expect_result("t2", 32'h8000_0000, 1'b0, 1'b1);
        send(32'h8000_0000, 32'h8000_0000, 1'b0);
        expect_result("t3a", 32'h0000_0000, 1'b1, 1'b1);
        send(32'h1234_5678, 32'h1111_1111, 1'b0);
        expect_result("t3b", 32'h2345_6789, 1'b0, 1'b0);

        // Backpressure: result must hold for 10 stalled cycles, then hand off once.
        out_ready = 1'b0;
        send(32'h4000_0000, 32'h4000_0000, 1'b0);
        expect_result("t4", 32'h8000_0000, 1'b0, 1'b1);
        repeat (10) begin
            @(negedge clk);
            check("bp_valid", out_valid, 1);
            check("bp_in_ready", in_ready, 0);
            check("bp_sum", sum, 32'h8000_0000);
            check("bp_ov", overflow, 1);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(negedge clk);
        check("handoff_valid", out_valid, 1);
        @(negedge clk);
        check("after_handoff_in_ready", in_ready, 1);
        check("after_handoff_valid", out_valid, 0);
        @(posedge clk);
        #1;

        // Abort mid-operation: reset lands on the edge that would process chunk 2.
        send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (8) begin
            @(negedge clk);
            check("abort_valid", out_valid, 0);
            check("abort_in_ready", in_ready, 1);
            check("abort_co", carry_out, 0);
        end
        @(posedge clk);
        #1;
        send(32'h0000_0005, 32'h0000_0003, 1'b0);
        expect_result("t5", 32'h0000_0008, 1'b0, 1'b0);

        // Back-to-back random traffic, checked by the model every cycle.
        b2b      = 1'b1;
        last_acc = -1;
        for (int i = 0; i < 100; i++) send($urandom, $urandom, 1'b1);
        in_valid = 1'b0;
        repeat (WORDS + 4) @(posedge clk);
        b2b = 1'b0;

        repeat (3) @(negedge clk);
        mon_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
